systolic_fifo_sequencer: RTL

//   Sequences one systolic-array input FIFO (load / shift / load_values port set).

---
 rtl/systolic_fifo_sequencer_if.sv | 33 +++
 rtl/systolic_fifo_sequencer.sv | 91 +++++++++
 2 files changed

// File: rtl/systolic_fifo_sequencer_if.sv
// Handshake and FIFO-control bundle between the scratchpad read path, the
// sequencer and one systolic-array input FIFO.
interface systolic_fifo_sequencer_if #(
   parameter int ARRAY_DIM = 4,
   parameter int DATA_W    = 16
);
   localparam int ROW_W   = DATA_W * ARRAY_DIM;
   localparam int N_SHIFT = 2 * ARRAY_DIM - 1;
   localparam int CNT_W   = $clog2(N_SHIFT + 1);

   logic             start;
   logic             row_valid;
   logic [ROW_W-1:0] row_data;
   logic             row_ready;
   logic             array_ready;
   logic             fifo_load;
   logic             fifo_shift;
   logic [ROW_W-1:0] fifo_load_values;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] cnt;

   // master drives the requests (memory side / array side), slave is the sequencer
   modport master (
      output start, row_valid, row_data, array_ready,
      input  row_ready, fifo_load, fifo_shift, fifo_load_values, busy, done, cnt
   );

   modport slave (
      input  start, row_valid, row_data, array_ready,
      output row_ready, fifo_load, fifo_shift, fifo_load_values, busy, done, cnt
   );
endinterface

// File: rtl/systolic_fifo_sequencer.sv
// Loads one ARRAY_DIM-row tile into a systolic input FIFO, then issues the
// 2*ARRAY_DIM-1 shifts that drain the skewed FIFO into the array.
module systolic_fifo_sequencer #(
   parameter int ARRAY_DIM = 4,
   parameter int DATA_W    = 16
) (
   input  logic                      CLK,
   input  logic                      nRST,
   systolic_fifo_sequencer_if.slave  bus
);
   localparam int ROW_W   = DATA_W * ARRAY_DIM;
   localparam int N_SHIFT = 2 * ARRAY_DIM - 1;
   localparam int CNT_W   = $clog2(N_SHIFT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt_q;
   logic             row_ready_q;
   logic             busy_q;
   logic             done_q;
   logic             load_hs;
   logic             shift_go;

   // row_ready_q is high exactly while in LOAD, so it doubles as the state decode
   assign load_hs  = row_ready_q & bus.row_valid;
   assign shift_go = (state == SHIFT) & bus.array_ready;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state       <= IDLE;
         cnt_q       <= '0;
         row_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state       <= LOAD;
                  cnt_q       <= '0;
                  row_ready_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            LOAD: begin
               if (load_hs) begin
                  if (cnt_q == CNT_W'(ARRAY_DIM - 1)) begin
                     state       <= SHIFT;
                     cnt_q       <= '0;
                     row_ready_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (shift_go) begin
                  if (cnt_q == CNT_W'(N_SHIFT - 1)) begin
                     state  <= DONE;
                     cnt_q  <= '0;
                     done_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            DONE: begin
               // start is not sampled here, so a request during DONE is dropped
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               cnt_q       <= '0;
               row_ready_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.row_ready        = row_ready_q;
   assign bus.fifo_load        = load_hs;
   assign bus.fifo_shift       = shift_go;
   assign bus.fifo_load_values = load_hs ? bus.row_data : '0;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.cnt              = cnt_q;
endmodule
